// File: rtl/mem_data_access.sv
// mem_data_access: MEM-stage data memory access controller.
// Issues one request per load/store over an addr_ok/data_ok handshake bus,
// holds the pipeline while the access is in flight and returns the aligned,
// sign/zero-extended load result together with a one-cycle ld_valid pulse.
// Optional feature: define MEM_ALIGN_CHECK_EN to trap misaligned halfword and
// word accesses as adel/ades in IDLE instead of putting them on the bus.
module mem_data_access (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_data_en,
  input  logic [3:0]  mem_data_ren,
  input  logic [3:0]  mem_data_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        mem_loadX,
  input  logic        flush,
  output logic        stall_out,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  output logic [3:0]  data_wstrb,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        adel,
  output logic        ades
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    DATA   = 3'd2,
    DONE   = 3'd3,
    CANCEL = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        cancel_pend_q, cancel_pend_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        wr_q, wr_d;
  logic        rd_q, rd_d;
  logic [1:0]  size_q, size_d;
  logic        loadx_q, loadx_d;
  logic [31:0] ld_data_q, ld_data_d;

  logic [3:0]  lane_mask;
  logic [1:0]  size_in;
  logic        wr_in;
  logic        rd_in;
  logic        access_in;
  logic        misalign_in;
  logic        issue;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] ld_ext;

  // Decode the incoming instruction: access width from the lane pattern,
  // direction from the enables, and whether it may be issued this cycle.
  always_comb begin
    lane_mask = mem_data_ren | mem_data_wen;
    wr_in     = |mem_data_wen;
    rd_in     = |mem_data_ren;
    access_in = mem_valid & mem_data_en & ~flush;
    case (lane_mask)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size_in = 2'd0;
      4'b0011, 4'b1100:                   size_in = 2'd1;
      default:                            size_in = 2'd2;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  // Halfwords need an even address, words a 4-byte aligned one.
  assign misalign_in = ((size_in == 2'd1) & mem_addr[0]) |
                       ((size_in == 2'd2) & (mem_addr[1:0] != 2'b00));
`else
  // Misaligned accesses go to the bus exactly as presented.
  assign misalign_in = 1'b0;
`endif

  assign issue = access_in & ~misalign_in;

  // Pick the addressed lane out of the returned word and extend it.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    byte_sel = data_rdata[7:0];
      2'd1:    byte_sel = data_rdata[15:8];
      2'd2:    byte_sel = data_rdata[23:16];
      default: byte_sel = data_rdata[31:24];
    endcase
    half_sel = addr_q[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (size_q)
      2'd0:    ld_ext = loadx_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'd1:    ld_ext = loadx_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: ld_ext = data_rdata;
    endcase
  end

  // Next-state logic: handshake sequencing, cancel tracking, request capture.
  always_comb begin
    state_d       = state_q;
    cancel_pend_d = cancel_pend_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    wr_d          = wr_q;
    rd_d          = rd_q;
    size_d        = size_q;
    loadx_d       = loadx_q;
    ld_data_d     = ld_data_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d       = ADDR;
          cancel_pend_d = 1'b0;
          addr_d        = mem_addr;
          wdata_d       = mem_wdata;
          wstrb_d       = mem_data_wen;
          wr_d          = wr_in;
          rd_d          = rd_in;
          size_d        = size_in;
          loadx_d       = mem_loadX;
        end
      end
      ADDR: begin
        // The request cannot be withdrawn once raised; a flush only
        // remembers that the data phase must be thrown away.
        if (data_addr_ok) begin
          state_d       = (cancel_pend_q | flush) ? CANCEL : DATA;
          cancel_pend_d = 1'b0;
        end else if (flush) begin
          cancel_pend_d = 1'b1;
        end
      end
      DATA: begin
        if (data_data_ok) begin
          ld_data_d = ld_ext;
          // Data landing in the same cycle as a flush is already drained.
          state_d   = flush ? IDLE : DONE;
        end else if (flush) begin
          state_d = CANCEL;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      CANCEL: begin
        if (data_data_ok) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and captured-request registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      cancel_pend_q <= 1'b0;
      addr_q        <= 32'h0;
      wdata_q       <= 32'h0;
      wstrb_q       <= 4'h0;
      wr_q          <= 1'b0;
      rd_q          <= 1'b0;
      size_q        <= 2'd0;
      loadx_q       <= 1'b0;
      ld_data_q     <= 32'h0;
    end else begin
      state_q       <= state_d;
      cancel_pend_q <= cancel_pend_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      wr_q          <= wr_d;
      rd_q          <= rd_d;
      size_q        <= size_d;
      loadx_q       <= loadx_d;
      ld_data_q     <= ld_data_d;
    end
  end

  // Pipeline stall, bus request and load completion, all forced low in reset.
  always_comb begin
    stall_out = 1'b0;
    data_req  = 1'b0;
    ld_valid  = 1'b0;
    if (resetn) begin
      case (state_q)
        IDLE, CANCEL: stall_out = issue;
        ADDR: begin
          stall_out = 1'b1;
          data_req  = 1'b1;
        end
        DATA:    stall_out = 1'b1;
        DONE:    ld_valid  = rd_q & ~flush;
        default: stall_out = 1'b0;
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  // Address-error pulses while the misaligned instruction sits in IDLE.
  always_comb begin
    adel = resetn & (state_q == IDLE) & access_in & misalign_in & ~wr_in;
    ades = resetn & (state_q == IDLE) & access_in & misalign_in & wr_in;
  end
`else
  assign adel = 1'b0;
  assign ades = 1'b0;
`endif

  assign data_wr    = wr_q;
  assign data_size  = size_q;
  assign data_addr  = addr_q;
  assign data_wdata = wdata_q;
  assign data_wstrb = wstrb_q;
  assign ld_data    = ld_data_q;

endmodule

// File: tb/tb_mem_data_access.sv
// Testbench for mem_data_access: directed cases with literal expectations
// followed by randomized loads/stores, flushes and bus delays. A negedge
// compare process checks every cycle against transaction-level expectations.
module tb_mem_data_access;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid, mem_data_en, mem_loadX, flush;
  logic [3:0]  mem_data_ren, mem_data_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic        stall_out, ld_valid, data_req, data_wr, adel, ades;
  logic [31:0] ld_data, data_addr, data_wdata, data_rdata;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;

  mem_data_access dut (
    .clk(clk), .resetn(resetn),
    .mem_valid(mem_valid), .mem_data_en(mem_data_en),
    .mem_data_ren(mem_data_ren), .mem_data_wen(mem_data_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_loadX(mem_loadX),
    .flush(flush), .stall_out(stall_out), .ld_data(ld_data), .ld_valid(ld_valid),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .adel(adel), .ades(ades)
  );

  always #5 clk = ~clk;

`ifdef MEM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  // Expected outputs for the current cycle, written by the stimulus process.
  logic        chk_en = 1'b0, exp_rst = 1'b0;
  logic        exp_stall, exp_req, exp_ldv, exp_adel, exp_ades, exp_wr;
  logic [1:0]  exp_size;
  logic [31:0] exp_addr, exp_wdata, exp_ld;
  logic [3:0]  exp_wstrb;
  int          checks = 0;
  int          failures = 0;
  int          txn_no = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h time=%0t", name, act, req, $time);
    end
  endtask

  // Single compare process, sampling half a cycle away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_rst) begin
        chk("rst_stall", 32'(stall_out), 32'h0);
        chk("rst_req", 32'(data_req), 32'h0);
        chk("rst_ld_valid", 32'(ld_valid), 32'h0);
        chk("rst_adel", 32'(adel), 32'h0);
        chk("rst_ades", 32'(ades), 32'h0);
        chk("rst_wr", 32'(data_wr), 32'h0);
        chk("rst_size", 32'(data_size), 32'h0);
        chk("rst_addr", data_addr, 32'h0);
        chk("rst_wdata", data_wdata, 32'h0);
        chk("rst_wstrb", 32'(data_wstrb), 32'h0);
        chk("rst_ld_data", ld_data, 32'h0);
      end else begin
        chk("stall_out", 32'(stall_out), 32'(exp_stall));
        chk("data_req", 32'(data_req), 32'(exp_req));
        chk("ld_valid", 32'(ld_valid), 32'(exp_ldv));
        chk("adel", 32'(adel), 32'(exp_adel));
        chk("ades", 32'(ades), 32'(exp_ades));
        if (exp_req) begin
          chk("data_wr", 32'(data_wr), 32'(exp_wr));
          chk("data_size", 32'(data_size), 32'(exp_size));
          chk("data_addr", data_addr, exp_addr);
          chk("data_wdata", data_wdata, exp_wdata);
          chk("data_wstrb", 32'(data_wstrb), 32'(exp_wstrb));
        end
        if (exp_ldv) chk("ld_data", ld_data, exp_ld);
      end
    end
  end

  // Reference rules: access width from the lane pattern.
  function automatic logic [1:0] size_of(input logic [3:0] mask);
    if ($countones(mask) == 1) return 2'd0;
    if (mask == 4'b0011 || mask == 4'b1100) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
  endfunction

  // Reference load result computed arithmetically.
  function automatic logic [31:0] load_model(input logic [31:0] rdata, input logic [1:0] sz,
                                              input logic [31:0] a, input logic loadx);
    longint v;
    int     bits;
    if (sz == 2'd2) return rdata;
    if (sz == 2'd0) begin
      bits = 8;
      v = longint'((rdata >> (8 * a[1:0])) % 256);
    end else begin
      bits = 16;
      v = longint'((rdata >> (16 * a[1])) % 65536);
    end
    if (!loadx && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return v[31:0];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_clear();
    exp_rst   = 1'b0;
    exp_stall = 1'b0;
    exp_req   = 1'b0;
    exp_ldv   = 1'b0;
    exp_adel  = 1'b0;
    exp_ades  = 1'b0;
  endtask

  // One load/store from presentation in IDLE to the idle cycle after it.
  // fl_mode: 0 none, 1 flush in ADDR cycle fl_at, 2 flush in DATA cycle fl_at
  // (before data_ok), 3 flush in the completion cycle.
  task automatic access(input logic [3:0] ren, input logic [3:0] wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input logic loadx,
                        input int a_dly, input int d_dly, input int fl_mode, input int fl_at,
                        input logic use_lit, input logic [31:0] lit);
    logic [1:0]  sz;
    logic        mis;
    logic        killed;
    logic [31:0] want;
    sz   = size_of(ren | wen);
    mis  = misaligned(sz, addr);
    want = use_lit ? lit : load_model(rdata, sz, addr, loadx);
    txn_no++;
    $display("txn %0d ren=%h wen=%h addr=%h loadX=%0d a_dly=%0d d_dly=%0d flush_mode=%0d expect_ld=%h",
             txn_no, ren, wen, addr, loadx, a_dly, d_dly, fl_mode, want);
    mem_valid = 1'b1; mem_data_en = 1'b1; mem_data_ren = ren; mem_data_wen = wen;
    mem_addr = addr; mem_wdata = wdata; mem_loadX = loadx;
    flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
    exp_clear();
    exp_wr = |wen; exp_size = sz; exp_addr = addr; exp_wdata = wdata; exp_wstrb = wen;
    if (ALIGN_EN && mis) begin
      exp_adel = (wen == 4'h0);
      exp_ades = (wen != 4'h0);
      cyc();
      mem_valid = 1'b0;
      exp_clear();
      cyc();
      return;
    end
    exp_stall = 1'b1;
    cyc();
    killed = 1'b0;
    for (int i = 0; i <= a_dly; i++) begin
      data_addr_ok = (i == a_dly);
      data_data_ok = (i == a_dly) ? 1'($urandom_range(0, 1)) : 1'b0;
      flush = (fl_mode == 1 && i == fl_at);
      exp_clear(); exp_req = 1'b1; exp_stall = 1'b1;
      cyc();
      if (flush) begin killed = 1'b1; mem_valid = 1'b0; end
    end
    data_addr_ok = 1'b0; flush = 1'b0;
    for (int i = 0; i <= d_dly; i++) begin
      data_data_ok = (i == d_dly);
      data_rdata = (i == d_dly) ? rdata : $urandom;
      flush = (fl_mode == 2 && !killed && i == fl_at);
      exp_clear(); exp_stall = !killed;
      cyc();
      if (flush) begin killed = 1'b1; mem_valid = 1'b0; end
    end
    data_data_ok = 1'b0; flush = 1'b0; data_rdata = $urandom;
    if (!killed) begin
      flush = (fl_mode == 3);
      exp_clear(); exp_ldv = (ren != 4'h0) && (fl_mode != 3); exp_ld = want;
      cyc();
      flush = 1'b0;
    end
    mem_valid = 1'b0;
    exp_clear();
    cyc();
  endtask

  task automatic non_mem(input int n);
    for (int i = 0; i < n; i++) begin
      mem_valid = 1'b1; mem_data_en = 1'b0;
      mem_data_ren = 4'($urandom); mem_data_wen = 4'h0; mem_addr = $urandom;
      exp_clear();
      cyc();
    end
    mem_valid = 1'b0;
  endtask

  task automatic rand_txn();
    int          kind, r, a_dly, d_dly, fl_mode, fl_at;
    logic        wr;
    logic [31:0] a;
    logic [3:0]  mask;
    kind = $urandom_range(0, 2);
    wr   = 1'($urandom_range(0, 1));
    a    = $urandom;
    if (kind == 1 && $urandom_range(0, 7) != 0) a[0] = 1'b0;
    if (kind == 2 && $urandom_range(0, 7) != 0) a[1:0] = 2'b00;
    if (kind == 0) mask = 4'b0001 << a[1:0];
    else if (kind == 1) mask = a[1] ? 4'b1100 : 4'b0011;
    else mask = 4'b1111;
    a_dly = $urandom_range(0, 3);
    d_dly = $urandom_range(0, 3);
    r = $urandom_range(0, 9);
    fl_mode = (r <= 6) ? 0 : r - 6;
    fl_at = 0;
    if (fl_mode == 1) fl_at = $urandom_range(0, a_dly);
    if (fl_mode == 2) begin
      if (d_dly == 0) d_dly = 1;
      fl_at = $urandom_range(0, d_dly - 1);
    end
    access(wr ? 4'h0 : mask, wr ? mask : 4'h0, a, $urandom, $urandom, 1'($urandom_range(0, 1)),
           a_dly, d_dly, fl_mode, fl_at, 1'b0, 32'h0);
    if ($urandom_range(0, 3) == 0) non_mem($urandom_range(1, 2));
  endtask

  initial begin
    resetn = 1'b0; mem_valid = 1'b0; mem_data_en = 1'b0; mem_data_ren = 4'h0;
    mem_data_wen = 4'h0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_loadX = 1'b0;
    flush = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    exp_clear();
    repeat (2) @(posedge clk);
    #1;
    exp_rst = 1'b1; chk_en = 1'b1;
    cyc();
    resetn = 1'b1;
    exp_clear();
    cyc();

    // lb from byte 3, sign-extended, immediate handshake.
    access(4'b1000, 4'h0, 32'h0000_0003, 32'h0, 32'h8011_2233, 1'b0, 0, 0, 0, 0, 1'b1, 32'hFFFF_FF80);
    // sw with addr_ok three cycles late.
    access(4'h0, 4'hF, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 1'b0, 3, 0, 0, 0, 1'b0, 32'h0);
    // lhu from upper halfword.
    access(4'b1100, 4'h0, 32'h0000_2002, 32'h0, 32'hABCD_1234, 1'b1, 0, 1, 0, 0, 1'b1, 32'h0000_ABCD);
    // lh sign-extended from lower halfword.
    access(4'b0011, 4'h0, 32'h0000_2000, 32'h0, 32'h1234_9876, 1'b0, 1, 0, 0, 0, 1'b1, 32'hFFFF_9876);
    // flush during ADDR, request held, data absorbed in CANCEL.
    access(4'hF, 4'h0, 32'h0000_0040, 32'h0, 32'h5555_AAAA, 1'b0, 2, 1, 1, 0, 1'b0, 32'h0);
    // flush together with addr_ok.
    access(4'hF, 4'h0, 32'h0000_0044, 32'h0, 32'h1111_2222, 1'b0, 1, 0, 1, 1, 1'b0, 32'h0);
    // misaligned lw.
    access(4'hF, 4'h0, 32'h0000_3001, 32'h0, 32'hCAFE_F00D, 1'b0, 0, 0, 0, 0, 1'b1, 32'hCAFE_F00D);
    // misaligned sh.
    access(4'h0, 4'b0011, 32'h0000_3005, 32'h0000_BEEF, 32'h0, 1'b0, 0, 0, 0, 0, 1'b0, 32'h0);
    // flush in DATA, then flush in the completion cycle.
    access(4'hF, 4'h0, 32'h0000_0080, 32'h0, 32'h0BAD_0BAD, 1'b0, 0, 2, 2, 1, 1'b0, 32'h0);
    access(4'b0001, 4'h0, 32'h0000_0084, 32'h0, 32'h0000_00FF, 1'b1, 0, 0, 3, 0, 1'b0, 32'h0);
    non_mem(3);

    // Reset while in DATA: access abandoned, late data_ok ignored.
    mem_valid = 1'b1; mem_data_en = 1'b1; mem_data_ren = 4'hF; mem_data_wen = 4'h0;
    mem_addr = 32'h0000_5000; mem_wdata = 32'h0; mem_loadX = 1'b0;
    exp_clear(); exp_stall = 1'b1;
    cyc();
    data_addr_ok = 1'b1;
    exp_clear(); exp_req = 1'b1; exp_stall = 1'b1;
    exp_wr = 1'b0; exp_size = 2'd2; exp_addr = 32'h0000_5000; exp_wdata = 32'h0; exp_wstrb = 4'h0;
    cyc();
    data_addr_ok = 1'b0;
    resetn = 1'b0; chk_en = 1'b0;
    cyc();
    exp_clear(); exp_rst = 1'b1; chk_en = 1'b1;
    cyc();
    resetn = 1'b1; mem_valid = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    exp_clear();
    cyc();
    data_data_ok = 1'b0;
    access(4'b0100, 4'h0, 32'h0000_6002, 32'h0, 32'h00F0_0000, 1'b0, 0, 0, 0, 0, 1'b1, 32'hFFFF_FFF0);

    for (int n = 0; n < 200; n++) rand_txn();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
